piso_serializer: RTL and testbench

Parallel-in/serial-out transmitter that loads a WIDTH-bit word and drives it one bit per clock onto a single serial line. It is the sending end of the single-bit data path captured by the async-reset D flip-flop and shift-register receivers. A one-cycle valid/ready handshake accepts words, a frame strobe qualifies each bit, and a done pulse marks the end of a frame.

---
 rtl/piso_serializer.sv | 137 +++++++++++++
 tb/tb_piso_serializer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter: valid/ready word load, one bit per clock, frame strobe, done pulse.
// Optional feature macro: PARITY_EN appends one even-parity bit to every frame.
module piso_serializer #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             reset_async,
   input  logic [WIDTH-1:0] data_in,
   input  logic             valid_in,
   output logic             ready_out,
   output logic             serial_out,
   output logic             frame_out,
   output logic             done
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
`ifdef PARITY_EN
      PARITY = 2'd2,
`endif
      DONE   = 2'd3
   } state_t;

   state_t           state_reg;
   state_t           state_next;
   logic [WIDTH-1:0] shift_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic             serial_reg;
`ifdef PARITY_EN
   logic             parity_reg;
`endif

   logic             last_bit;
   logic             load_head;
   logic             next_head;
   logic [WIDTH-1:0] shift_next;
   logic             tail_bit;

   assign last_bit   = (cnt_reg == LAST_CNT);
   assign load_head  = MSB_FIRST ? data_in[WIDTH-1] : data_in[0];
   assign next_head  = MSB_FIRST ? shift_reg[WIDTH-2] : shift_reg[1];
   assign shift_next = MSB_FIRST ? {shift_reg[WIDTH-2:0], 1'b0}
                                 : {1'b0, shift_reg[WIDTH-1:1]};
`ifdef PARITY_EN
   assign tail_bit   = parity_reg;
`else
   assign tail_bit   = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_async) begin
      if (!reset_async) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      ready_out  = 1'b0;
      frame_out  = 1'b0;
      done       = 1'b0;
      case (state_reg)
         IDLE: begin
            ready_out = 1'b1;
            if (valid_in) begin
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            frame_out = 1'b1;
            if (last_bit) begin
`ifdef PARITY_EN
               state_next = PARITY;
`else
               state_next = DONE;
`endif
            end
         end
`ifdef PARITY_EN
         PARITY: begin
            frame_out  = 1'b1;
            state_next = DONE;
         end
`endif
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // serial_reg always holds the bit for the state being entered, so it is
   // valid straight after the accepting edge and returns to 0 after the tail.
   always_ff @(posedge clk or negedge reset_async) begin
      if (!reset_async) begin
         shift_reg  <= '0;
         cnt_reg    <= '0;
         serial_reg <= 1'b0;
`ifdef PARITY_EN
         parity_reg <= 1'b0;
`endif
      end else begin
         case (state_reg)
            IDLE: begin
               if (valid_in) begin
                  shift_reg  <= data_in;
                  cnt_reg    <= '0;
                  serial_reg <= load_head;
`ifdef PARITY_EN
                  parity_reg <= ^data_in;
`endif
               end
            end
            SHIFT: begin
               cnt_reg    <= cnt_reg + CNT_W'(1);
               shift_reg  <= shift_next;
               serial_reg <= last_bit ? tail_bit : next_head;
            end
            default: begin
               serial_reg <= 1'b0;
            end
         endcase
      end
   end

   assign serial_out = serial_reg;

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: one MSB-first and one LSB-first instance share clock and reset.
module tb_piso_serializer;

   localparam int W = 8;
`ifdef PARITY_EN
   localparam int FLEN = W + 1;
`else
   localparam int FLEN = W;
`endif

   logic         clk;
   logic         rst_n;
   logic [W-1:0] din [2];
   logic         vld [2];
   logic         rdy [2];
   logic         ser [2];
   logic         frm [2];
   logic         dn  [2];

   bit exp_q [2][$];
   int exp_done [2];
   int done_seen [2];

   int n_vec  = 0;
   int n_fail = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_dut
         piso_serializer #(
            .WIDTH(W),
            .MSB_FIRST((gi == 0) ? 1'b1 : 1'b0)
         ) dut (
            .clk        (clk),
            .reset_async(rst_n),
            .data_in    (din[gi]),
            .valid_in   (vld[gi]),
            .ready_out  (rdy[gi]),
            .serial_out (ser[gi]),
            .frame_out  (frm[gi]),
            .done       (dn[gi])
         );

         int flen = 0;
         bit dn_prev = 0;

         // Monitor: pops one expected bit per frame cycle, checks framing and done.
         always @(negedge clk) begin
            if (!rst_n) begin
               chk($sformatf("reset_ready[%0d]", gi), int'(rdy[gi]), 1);
               chk($sformatf("reset_serial[%0d]", gi), int'(ser[gi]), 0);
               chk($sformatf("reset_frame[%0d]", gi), int'(frm[gi]), 0);
               chk($sformatf("reset_done[%0d]", gi), int'(dn[gi]), 0);
               flen = 0;
               dn_prev = 0;
            end else begin
               if (frm[gi]) begin
                  chk($sformatf("ready_in_frame[%0d]", gi), int'(rdy[gi]), 0);
                  if (exp_q[gi].size() == 0) begin
                     n_vec++;
                     n_fail++;
                     $display("FAIL unexpected_bit[%0d]: got frame bit %0d expected no frame", gi, ser[gi]);
                  end else begin
                     chk($sformatf("serial_bit[%0d]", gi), int'(ser[gi]), int'(exp_q[gi].pop_front()));
                  end
                  flen++;
               end else begin
                  chk($sformatf("serial_idle[%0d]", gi), int'(ser[gi]), 0);
               end
               if (dn_prev) begin
                  chk($sformatf("done_width[%0d]", gi), int'(dn[gi]), 0);
                  chk($sformatf("ready_after_done[%0d]", gi), int'(rdy[gi]), 1);
               end
               if (dn[gi]) begin
                  chk($sformatf("frame_len[%0d]", gi), flen, FLEN);
                  chk($sformatf("done_frame_off[%0d]", gi), int'(frm[gi]), 0);
                  done_seen[gi]++;
                  flen = 0;
               end
               dn_prev = dn[gi];
            end
         end
      end
   endgenerate

   task automatic wait_ready(input int s);
      int t;
      t = 0;
      @(negedge clk);
      while (!rdy[s] && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!rdy[s]) begin
         n_vec++;
         n_fail++;
         $display("FAIL ready_timeout[%0d]: got ready 0 expected 1 within 50 cycles", s);
      end
   endtask

   // Issues one word and pushes its expected bit sequence; busy_cycles keeps
   // valid_in high with 8'h00 for that many cycles while the frame runs.
   task automatic send(input int s, input logic [W-1:0] d, input int busy_cycles);
      wait_ready(s);
      din[s] = d;
      vld[s] = 1'b1;
      for (int i = 0; i < W; i++) begin
         exp_q[s].push_back((s == 0) ? d[W-1-i] : d[i]);
      end
`ifdef PARITY_EN
      exp_q[s].push_back(^d);
`endif
      @(posedge clk);
      #1;
      if (busy_cycles > 0) begin
         din[s] = '0;
         repeat (busy_cycles) @(posedge clk);
         #1;
      end
      vld[s] = 1'b0;
   endtask

   initial begin
      rst_n  = 1'b1;
      din[0] = 8'hA5;
      din[1] = 8'hA5;
      vld[0] = 1'b1;
      vld[1] = 1'b1;
      exp_done[0] = 0;
      exp_done[1] = 0;
      done_seen[0] = 0;
      done_seen[1] = 0;
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      vld[0] = 1'b0;
      vld[1] = 1'b0;
      rst_n  = 1'b1;

      send(0, 8'hA5, 0); exp_done[0]++;
      send(1, 8'h01, 0); exp_done[1]++;
      send(1, 8'hB4, 0); exp_done[1]++;
      send(0, 8'hFF, 5); exp_done[0]++;
      send(0, 8'h96, 0); exp_done[0]++;

      // Mid-frame reset: after bit 3 of 8'hC3 has been sampled, between edges.
      send(0, 8'hC3, 0);
      repeat (3) @(posedge clk);
      #7 rst_n = 1'b0;
      #1;
      chk("midreset_ready", int'(rdy[0]), 1);
      chk("midreset_serial", int'(ser[0]), 0);
      chk("midreset_frame", int'(frm[0]), 0);
      chk("midreset_done", int'(dn[0]), 0);
      exp_q[0].delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      send(0, 8'h3C, 0); exp_done[0]++;
      send(0, 8'h07, 0); exp_done[0]++;
      send(0, 8'h03, 0); exp_done[0]++;
      wait_ready(0);
      wait_ready(1);
      repeat (3) @(negedge clk);

      for (int s = 0; s < 2; s++) begin
         chk($sformatf("done_count[%0d]", s), done_seen[s], exp_done[s]);
         chk($sformatf("queue_empty[%0d]", s), exp_q[s].size(), 0);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
